count_checker: RTL and testbench

- Receive-side checker for the 8-bit enabled up-counter interface: `q`, plus the counter's enable and synchronous clear as seen at the counter.
- Predicts each next count value and flags any sample that breaks the sequence; counts the errors.
- Sits next to any counter instance in the design as a bus monitor for simulation and silicon debug.

---
 rtl/count_checker_pkg.sv | 27 ++
 rtl/count_predictor.sv | 54 +++++
 rtl/count_checker.sv | 162 ++++++++++++++++
 tb/tb_count_checker.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_checker_pkg.sv
// -----------------------------------------------------------------------------
// count_checker_pkg
//   Shared definitions for the enabled up-counter monitor: the checker state
//   encoding and the default sizing constants used by count_checker and
//   count_predictor.
//
//   Optional build macro understood by the users of this package:
//     COUNT_CHECK_HALT_ON_ERR_EN - first mismatch while locked freezes the
//                                  checker in ST_HALT instead of resyncing.
// -----------------------------------------------------------------------------
package count_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_HALT    = 2'd3
  } state_e;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_ERR_W    = 8;
  localparam int DEF_SYNC_LEN = 2;

  // Match counter width; SYNC_LEN is limited to 1..15.
  localparam int MATCH_W = 4;

endpackage

// File: rtl/count_predictor.sv
// -----------------------------------------------------------------------------
// count_predictor
//   Registered next-value predictor for an enabled up-counter with a
//   synchronous clear, plus the equality compare of the live count against the
//   stored prediction. Intended to be reused by other counter monitors.
//
// Ports:
//   clk         rising-edge clock shared with the monitored counter
//   reset       asynchronous active-low reset, clears the prediction to 0
//   hold        1 = keep the current prediction (freeze)
//   mon_clear   counter synchronous clear as seen at the counter
//   mon_enable  counter increment enable as seen at the counter
//   mon_q       counter output
//   expected    predicted value of mon_q for the current cycle
//   match       mon_q equals expected (combinational)
// -----------------------------------------------------------------------------
module count_predictor
  import count_checker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             mon_clear,
  input  logic             mon_enable,
  input  logic [WIDTH-1:0] mon_q,
  output logic [WIDTH-1:0] expected,
  output logic             match
);

  logic [WIDTH-1:0] pred_nxt;

  // Clear beats enable; the increment wraps naturally at 2^WIDTH.
  always_comb begin
    pred_nxt = mon_q;
    if (mon_clear) begin
      pred_nxt = '0;
    end else if (mon_enable) begin
      pred_nxt = mon_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      expected <= '0;
    end else if (!hold) begin
      expected <= pred_nxt;
    end
  end

  assign match = (mon_q == expected);

endmodule

// File: rtl/count_checker.sv
// -----------------------------------------------------------------------------
// count_checker
//   Receive-side monitor for an enabled up-counter. Predicts every next count
//   value, acquires lock after SYNC_LEN consecutive correct predictions and,
//   once locked, flags and counts every sample that breaks the sequence.
//
//   Build macro: COUNT_CHECK_HALT_ON_ERR_EN
//     defined   - first mismatch in LOCKED enters HALT: expected frozen at the
//                 missed value, no further compares, left only via chk_en=0
//                 or reset.
//     undefined - a mismatch in LOCKED falls back to ACQUIRE and resyncs.
//
// Ports:
//   clk         rising-edge clock, same as the monitored counter
//   reset       asynchronous active-low reset
//   chk_en      checker enable; 0 returns to IDLE on the next edge
//   mon_clear   counter synchronous clear
//   mon_enable  counter increment enable
//   mon_q       counter output
//   locked      high while in LOCKED
//   err_pulse   one-cycle pulse, registered, after each detected mismatch
//   err_count   saturating mismatch count since reset / last chk_en rise
//   expected    predicted value of mon_q for the current cycle
//
// state      | meaning
// -----------+-----------------------------------------------------------------
// ST_IDLE    | checker off, no compares; err_count held
// ST_ACQUIRE | hunting for SYNC_LEN consecutive matches; mismatches not errors
// ST_LOCKED  | tracking; a mismatch is an error
// ST_HALT    | frozen after the first locked mismatch (halt build only)
// -----------------------------------------------------------------------------
module count_checker
  import count_checker_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int SYNC_LEN = DEF_SYNC_LEN,
  parameter int ERR_W    = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chk_en,
  input  logic             mon_clear,
  input  logic             mon_enable,
  input  logic [WIDTH-1:0] mon_q,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  localparam logic [MATCH_W-1:0] SYNC_CNT = MATCH_W'(SYNC_LEN);
  localparam logic [ERR_W-1:0]   ERR_MAX  = '1;

  state_e               state, state_nxt;
  logic [MATCH_W-1:0]   match_cnt, match_cnt_nxt, match_cnt_inc;
  logic                 acq_first, acq_first_nxt;
  logic [ERR_W-1:0]     err_count_nxt;
  logic                 err_pulse_nxt;
  logic                 pred_hold;
  logic                 pred_match;

  count_predictor #(
    .WIDTH (WIDTH)
  ) u_pred (
    .clk        (clk),
    .reset      (reset),
    .hold       (pred_hold),
    .mon_clear  (mon_clear),
    .mon_enable (mon_enable),
    .mon_q      (mon_q),
    .expected   (expected),
    .match      (pred_match)
  );

  assign match_cnt_inc = match_cnt + MATCH_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      match_cnt <= '0;
      acq_first <= 1'b0;
      err_count <= '0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_cnt_nxt;
      acq_first <= acq_first_nxt;
      err_count <= err_count_nxt;
      err_pulse <= err_pulse_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    match_cnt_nxt = match_cnt;
    acq_first_nxt = 1'b0;
    err_count_nxt = err_count;
    err_pulse_nxt = 1'b0;
    pred_hold     = 1'b0;

    if (!chk_en) begin
      // Disable wins over anything seen on this edge.
      state_nxt     = ST_IDLE;
      match_cnt_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt     = ST_ACQUIRE;
          match_cnt_nxt = '0;
          acq_first_nxt = 1'b1;
          err_count_nxt = '0;
        end

        ST_ACQUIRE: begin
          // The prediction held on entry from IDLE is stale, so the first
          // cycle only loads a fresh one.
          if (!acq_first) begin
            if (pred_match) begin
              if (match_cnt_inc == SYNC_CNT) begin
                state_nxt     = ST_LOCKED;
                match_cnt_nxt = '0;
              end else begin
                match_cnt_nxt = match_cnt_inc;
              end
            end else begin
              match_cnt_nxt = '0;
            end
          end
        end

        ST_LOCKED: begin
          if (!pred_match) begin
            err_pulse_nxt = 1'b1;
            match_cnt_nxt = '0;
            if (err_count != ERR_MAX) begin
              err_count_nxt = err_count + ERR_W'(1);
            end
`ifdef COUNT_CHECK_HALT_ON_ERR_EN
            // Keep the missed prediction visible on expected.
            state_nxt = ST_HALT;
            pred_hold = 1'b1;
`else
            // Prediction reloads from the observed mon_q on this edge.
            state_nxt = ST_ACQUIRE;
`endif
          end
        end

        ST_HALT: begin
`ifdef COUNT_CHECK_HALT_ON_ERR_EN
          pred_hold = 1'b1;
`else
          state_nxt = ST_IDLE;
`endif
        end
      endcase
    end
  end

  assign locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_count_checker.sv
module tb_count_checker;

  localparam int SYNC_LEN = 2;
  localparam int ERR_MAX  = 255;
`ifdef COUNT_CHECK_HALT_ON_ERR_EN
  localparam bit HALT_BUILD = 1'b1;
`else
  localparam bit HALT_BUILD = 1'b0;
`endif

  // Reference model modes.
  localparam int M_OFF   = 0;
  localparam int M_HUNT  = 1;
  localparam int M_TRACK = 2;
  localparam int M_STOP  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       chk_en;
  logic       mon_clear;
  logic       mon_enable;
  logic [7:0] mon_q;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_count;
  logic [7:0] expected;

  int errors = 0;
  int checks = 0;

  int cnt;        // true value of the monitored counter
  int m_mode, m_exp, m_run, m_errs;
  bit m_fresh, m_pulse;
  int lock_edge;

  count_checker #(
    .WIDTH    (8),
    .SYNC_LEN (SYNC_LEN),
    .ERR_W    (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .chk_en     (chk_en),
    .mon_clear  (mon_clear),
    .mon_enable (mon_enable),
    .mon_q      (mon_q),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .expected   (expected)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_OFF;
    m_exp   = 0;
    m_run   = 0;
    m_errs  = 0;
    m_fresh = 1'b0;
    m_pulse = 1'b0;
  endtask

  // One clock edge of the checker's rules, applied to the sampled inputs.
  task automatic model_edge(input bit ce, input bit clr, input bit en, input int q);
    bit hit;
    bit frz;
    int old;
    hit     = (q == m_exp);
    old     = m_mode;
    m_pulse = 1'b0;
    if (!ce) begin
      m_mode = M_OFF;
      m_run  = 0;
    end else begin
      case (m_mode)
        M_OFF: begin
          m_mode  = M_HUNT;
          m_run   = 0;
          m_fresh = 1'b1;
          m_errs  = 0;
        end
        M_HUNT: begin
          if (m_fresh) m_fresh = 1'b0;
          else if (hit) begin
            m_run++;
            if (m_run >= SYNC_LEN) begin
              m_mode = M_TRACK;
              m_run  = 0;
            end
          end else m_run = 0;
        end
        M_TRACK: begin
          if (!hit) begin
            m_pulse = 1'b1;
            if (m_errs < ERR_MAX) m_errs++;
            m_run  = 0;
            m_mode = HALT_BUILD ? M_STOP : M_HUNT;
          end
        end
        default: ;
      endcase
    end
    frz = ce && (old == M_STOP || m_mode == M_STOP);
    if (!frz) m_exp = clr ? 0 : (en ? (q + 1) % 256 : q);
  endtask

  task automatic compare_all();
    chk("locked",    32'(locked),    32'(m_mode == M_TRACK));
    chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
    chk("err_count", 32'(err_count), 32'(m_errs));
    chk("expected",  32'(expected),  32'(m_exp));
  endtask

  // force_q >= 0 makes the counter jump to that value for this sample.
  task automatic step(input bit clr, input bit en, input int force_q);
    int q;
    q = (force_q >= 0) ? force_q : cnt;
    cnt = q;
    mon_clear  = clr;
    mon_enable = en;
    mon_q      = 8'(q);
    @(posedge clk);
    model_edge(chk_en, clr, en, q);
    cnt = clr ? 0 : (en ? (cnt + 1) % 256 : cnt);
    #1;
    compare_all();
  endtask

  task automatic count_to(input int target);
    for (int i = 0; i < 256 && cnt != target; i++) step(1'b0, 1'b1, -1);
  endtask

  task automatic bad_value(output int v);
    v = (cnt + int'($urandom_range(1, 255))) % 256;
  endtask

  initial begin
    int v;
    cnt        = 0;
    lock_edge  = -1;
    reset      = 1'b0;
    chk_en     = 1'b1;
    mon_clear  = 1'b0;
    mon_enable = 1'b0;
    mon_q      = 8'h00;
    model_reset();

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked",    32'(locked),    32'h0);
    chk("rst_err_pulse", 32'(err_pulse), 32'h0);
    chk("rst_err_count", 32'(err_count), 32'h0);
    chk("rst_expected",  32'(expected),  32'h0);
    reset = 1'b1;

    // Clear, then count from 0 for 300 edges including the 255->0 wrap.
    step(1'b1, 1'b0, -1);
    if (locked === 1'b1 && lock_edge < 0) lock_edge = 0;
    for (int i = 1; i <= 300; i++) begin
      step(1'b0, 1'b1, -1);
      if (locked === 1'b1 && lock_edge < 0) lock_edge = i;
    end
    chk("lock_edge", 32'(lock_edge), 32'd3);
    chk("no_err_300", 32'(err_count), 32'd0);

    // Single mismatch: 0x37 where 0x36 is predicted.
    count_to(8'h36);
    chk("pre_exp_36", 32'(expected), 32'h36);
    chk("pre_locked", 32'(locked), 32'h1);
    step(1'b0, 1'b1, 8'h37);
    chk("mis_pulse",  32'(err_pulse), 32'h1);
    chk("mis_count",  32'(err_count), 32'h1);
    chk("mis_locked", 32'(locked),    32'h0);
`ifndef COUNT_CHECK_HALT_ON_ERR_EN
    step(1'b0, 1'b1, -1);
    chk("mis_pulse_once", 32'(err_pulse), 32'h0);
    step(1'b0, 1'b1, -1);
    chk("relock", 32'(locked), 32'h1);
`else
    chk("halt_exp", 32'(expected), 32'h36);
    for (int i = 0; i < 4; i++) begin
      bad_value(v);
      step(1'b0, 1'b1, v);
      chk("halt_no_pulse", 32'(err_pulse), 32'h0);
    end
    chk("halt_count", 32'(err_count), 32'h1);
    chk("halt_exp_frozen", 32'(expected), 32'h36);
    chk_en = 1'b0;
    step(1'b0, 1'b1, -1);
    chk_en = 1'b1;
    step(1'b1, 1'b0, -1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, -1);
    chk("halt_resume_lock", 32'(locked), 32'h1);
`endif

    // Enable pattern 1,0,0,1 then clear while mon_q=0x80.
    count_to(8'h7e);
    step(1'b0, 1'b1, -1);  chk("pat_e1", 32'(expected), 32'h7f);
    step(1'b0, 1'b0, -1);  chk("pat_e0a", 32'(expected), 32'h7f);
    step(1'b0, 1'b0, -1);  chk("pat_e0b", 32'(expected), 32'h7f);
    step(1'b0, 1'b1, -1);  chk("pat_e1b", 32'(expected), 32'h80);
    chk("pat_q80", 32'(cnt), 32'h80);
    step(1'b1, 1'b1, -1);  chk("pat_clr", 32'(expected), 32'h00);
    chk("pat_no_pulse", 32'(err_pulse), 32'h0);

    // 300 mismatches in LOCKED: saturation, then chk_en 0->1 clears.
    for (int k = 0; k < 300; k++) begin
      bad_value(v);
      step(1'b0, 1'b1, v);
      step(1'b0, 1'b1, -1);
      step(1'b0, 1'b1, -1);
    end
`ifndef COUNT_CHECK_HALT_ON_ERR_EN
    chk("sat_count", 32'(err_count), 32'd255);
`else
    chk("halt_sat_count", 32'(err_count), 32'd1);
`endif
    chk_en = 1'b0;
    step(1'b0, 1'b1, -1);
    chk("dis_locked", 32'(locked), 32'h0);
`ifndef COUNT_CHECK_HALT_ON_ERR_EN
    chk("dis_hold_count", 32'(err_count), 32'd255);
`endif
    chk_en = 1'b1;
    step(1'b0, 1'b1, -1);
    chk("en_clears_count", 32'(err_count), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 3) chk_en = ~chk_en;
      if ($urandom_range(0, 99) < 5) begin
        bad_value(v);
        step($urandom_range(0, 99) < 5, $urandom_range(0, 99) < 75, v);
      end else begin
        step($urandom_range(0, 99) < 5, $urandom_range(0, 99) < 75, -1);
      end
    end

    // Asynchronous reset in the middle of LOCKED.
    chk_en = 1'b0;
    step(1'b0, 1'b1, -1);
    chk_en = 1'b1;
    step(1'b1, 1'b0, -1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, -1);
`ifndef COUNT_CHECK_HALT_ON_ERR_EN
    bad_value(v);
    step(1'b0, 1'b1, v);
    step(1'b0, 1'b1, -1);
    step(1'b0, 1'b1, -1);
    chk("pre_rst_count", 32'(err_count), 32'd1);
`endif
    chk("pre_rst_locked", 32'(locked), 32'h1);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_locked",    32'(locked),    32'h0);
    chk("arst_err_pulse", 32'(err_pulse), 32'h0);
    chk("arst_err_count", 32'(err_count), 32'h0);
    chk("arst_expected",  32'(expected),  32'h0);
    model_reset();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
